// File: rtl/rf_writeback_arbiter.sv
// Purpose: merges ALU and load results onto the single register-file write port.
// Latency: ALU result -> RegWrite 1 cycle; load push -> RegWrite >= 2 cycles.
// Backpressure: ALU never stalls and wins the slot. Loads wait in an in-order FIFO.
//   lsu_ready drops only when the FIFO is full.
// Ports:
//   clk, rst (async, active-high)
//   alu_valid/alu_rd/alu_data        : ALU result input, always accepted
//   lsu_valid/lsu_rd/lsu_data        : load result input, handshake with lsu_ready
//   RegWrite/WriteRegister/WriteData : registered register-file write port
//   query_rs/query_hit               : hazard query (combinational)
//   lsu_pending                      : FIFO non-empty
module rf_writeback_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LSU_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] query_rs,
  output logic              query_hit,
  output logic              lsu_pending
);

  localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(LSU_DEPTH);

  logic [ADDR_W-1:0] entryRd   [LSU_DEPTH];
  logic [DATA_W-1:0] entryData [LSU_DEPTH];
  logic [LSU_DEPTH-1:0] entryVld;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W:0]   count;

  logic aluTake;
  logic fifoPush;
  logic fifoPop;

  // Ready is a function of count alone: no push into a full FIFO even when it pops.
  assign lsu_ready   = (count != FULL_CNT);
  assign lsu_pending = (count != '0);

  // A load to x0 completes its handshake but is dropped here.
  assign fifoPush = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign aluTake  = alu_valid && (alu_rd != '0);
  // Pop decision uses the registered count, so a fresh entry waits one cycle.
  assign fifoPop  = !aluTake && (count != '0);

  // FIFO payload storage needs no reset; entryVld qualifies it.
  always_ff @(posedge clk) begin
    if (fifoPush) begin
      entryRd[wrPtr]   <= lsu_rd;
      entryData[wrPtr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      entryVld <= '0;
    end else begin
      if (fifoPush) begin
        wrPtr           <= wrPtr + PTR_W'(1);
        entryVld[wrPtr] <= 1'b1;
      end
      if (fifoPop) begin
        rdPtr           <= rdPtr + PTR_W'(1);
        entryVld[rdPtr] <= 1'b0;
      end
      if (fifoPush && !fifoPop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (fifoPop && !fifoPush) begin
        count <= count - (PTR_W + 1)'(1);
      end
    end
  end

  // Output register: ALU first, then FIFO head, else idle (index/data hold).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (aluTake) begin
      RegWrite      <= 1'b1;
      WriteRegister <= alu_rd;
      WriteData     <= alu_data;
    end else if (fifoPop) begin
      RegWrite      <= 1'b1;
      WriteRegister <= entryRd[rdPtr];
      WriteData     <= entryData[rdPtr];
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  // The output-register term covers a write landing at the same edge the
  // register file is read asynchronously.
  always_comb begin
    query_hit = 1'b0;
    if (query_rs != '0) begin
      if (RegWrite && (WriteRegister == query_rs)) begin
        query_hit = 1'b1;
      end
      for (int i = 0; i < LSU_DEPTH; i++) begin
        if (entryVld[i] && (entryRd[i] == query_rs)) begin
          query_hit = 1'b1;
        end
      end
    end
  end

endmodule
